puf_multi_cntrlr: RTL and testbench
===================================

PUF_MULTI_CNTRLR -- requirements
Module: puf_multi_cntrlr

Interface
REQ-001 SHALL have parameter MUX_LENGTH, default 16, meaning RO mux depth; SEL_W = $clog2(MUX_LENGTH).
REQ-002 SHALL have parameter REG_BIT_SIZE, default 40, meaning challenge word width; 2*SEL_W*NUM_PAIRS <= REG_BIT_SIZE is required.
REQ-003 SHALL have parameter NUM_PAIRS, default 4, meaning RO pairs evaluated per challenge.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have inputs i_start, i_op_mode, i_rx_ready, i_rx_valid, i_rx_done, i_exec_done, i_exec_resp, i_tx_done and i_abort, each 1 bit.
REQ-008 SHALL have input i_rx_data [REG_BIT_SIZE-1:0], the challenge word.
REQ-009 SHALL have output o_fsm_state [2:0], the current state code.
REQ-010 SHALL have outputs o_dcod_enable, o_exec_enable, o_tx_enable, o_dump_enable, o_busy and o_timeout_err, each 1 bit.
REQ-011 SHALL have outputs o_sel_mux_0 and o_sel_mux_1, each [SEL_W-1:0], the RO pair selects.
REQ-012 SHALL have output o_pair_idx [$clog2(NUM_PAIRS)-1:0], the pair under evaluation.
REQ-013 SHALL have output o_resp [NUM_PAIRS-1:0], the response bit vector.

Function
REQ-014 SHALL encode states as RESET=0, WAIT=1, RECEIVE=2, RO_DECODER=3, EXECUTE=4, TRANSMIT=5, DUMP=6, ERROR=7.
REQ-015 SHALL move RESET->WAIT on the first clock after reset release.
REQ-016 SHALL move WAIT->RECEIVE on the next edge when i_start && i_rx_ready.
REQ-017 SHALL, in RECEIVE, on i_rx_valid && i_rx_done: latch i_rx_data; clear pair_idx, o_resp and the debug flag; then go to RO_DECODER.
REQ-018 SHALL take pair k from challenge bits [2*SEL_W*k +: 2*SEL_W]: low SEL_W bits drive mux_0, high SEL_W bits drive mux_1.
REQ-019 SHALL stay in RO_DECODER for exactly 1 cycle: register the selects for pair_idx and assert o_dcod_enable.
REQ-020 SHALL go RO_DECODER->EXECUTE when the selects differ.
REQ-021 SHALL, when the selects are equal (degenerate pair), force o_resp[pair_idx]=0 and skip EXECUTE, advancing as in REQ-023.
REQ-022 SHALL assert o_exec_enable in EXECUTE and, on i_exec_done, store o_resp[pair_idx] <= i_exec_resp.
REQ-023 SHALL, on advance: if pair_idx==NUM_PAIRS-1, go to DUMP when the debug flag is set, else TRANSMIT; otherwise increment pair_idx and return to RO_DECODER.
REQ-024 SHALL set a sticky debug flag when i_op_mode is high in any RO_DECODER or EXECUTE cycle.
REQ-025 SHALL assert o_tx_enable in TRANSMIT and o_dump_enable in DUMP, and go to WAIT on i_tx_done.
REQ-026 SHALL hold o_resp stable from TRANSMIT/DUMP entry until the next RECEIVE completion.
REQ-027 SHALL run a watchdog that counts cycles in RECEIVE, EXECUTE, TRANSMIT and DUMP and clears on every state change.
REQ-028 SHALL, when the watchdog reaches TIMEOUT_CYC-1 without the awaited event, go to ERROR and set o_timeout_err.
REQ-029 SHALL let the awaited event win when it coincides with the final watchdog count (no ERROR).
REQ-030 SHALL, in ERROR, hold o_timeout_err=1 and go to WAIT, clearing o_timeout_err, once i_start=0.
REQ-031 SHALL, on i_abort in any state other than RESET, go to WAIT on the next edge and clear pair_idx, watchdog, o_resp and the debug flag.
REQ-032 SHALL apply priority abort > timeout > normal transition.
REQ-033 SHALL drive o_busy=1 in states RECEIVE through DUMP, else 0.
REQ-034 SHALL decode all enables from the state register only, with no combinational input-to-output paths.

Reset
REQ-035 SHALL, while rst_n=0 asynchronously: state=RESET, all enables=0, o_busy=0, o_timeout_err=0, selects=0, o_pair_idx=0, o_resp=0, watchdog=0, debug flag=0.
REQ-036 SHALL, on reset asserted mid-operation, abandon the operation immediately with no partial o_resp retained.

Verification
REQ-037 SHALL pass normal run: i_rx_data=40'h00_F0E1_D2C3, i_exec_resp 1,0,1,1 -> selects (3,C),(2,D),(1,E),(0,F); TRANSMIT with o_resp=4'b1101; WAIT after i_tx_done.
REQ-038 SHALL pass debug run: same data, i_op_mode pulsed 1 cycle during pair 1 EXECUTE -> DUMP with o_dump_enable=1 instead of TRANSMIT.
REQ-039 SHALL pass degenerate pair: pair 2 byte 8'h77 -> no EXECUTE for pair 2, o_resp[2]=0, total of 3 exec_enable windows.
REQ-040 SHALL pass timeout: i_exec_done withheld with TIMEOUT_CYC=16 -> ERROR after 16 EXECUTE cycles, o_timeout_err=1; i_start=0 -> WAIT, err cleared.
REQ-041 SHALL pass abort/reset: i_abort during pair 2 EXECUTE -> WAIT next edge, o_resp=0; then rst_n low mid-RECEIVE -> all outputs at REQ-035 values.

Source files
------------

// File: rtl/puf_multi_cntrlr.sv
// puf_multi_cntrlr: sequences RO-pair PUF evaluation (receive challenge, decode, execute, transmit/dump)
// with a per-state watchdog, abort and debug-dump path.
module puf_multi_cntrlr #(
    parameter int MUX_LENGTH   = 16,
    parameter int REG_BIT_SIZE = 40,
    parameter int NUM_PAIRS    = 4,
    parameter int TIMEOUT_CYC  = 1024,
    localparam int SEL_W       = $clog2(MUX_LENGTH),
    localparam int PI_W        = $clog2(NUM_PAIRS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_op_mode,
    input  logic                    i_rx_ready,
    input  logic                    i_rx_valid,
    input  logic                    i_rx_done,
    input  logic                    i_exec_done,
    input  logic                    i_exec_resp,
    input  logic                    i_tx_done,
    input  logic                    i_abort,
    input  logic [REG_BIT_SIZE-1:0] i_rx_data,
    output logic [2:0]              o_fsm_state,
    output logic                    o_dcod_enable,
    output logic                    o_exec_enable,
    output logic                    o_tx_enable,
    output logic                    o_dump_enable,
    output logic                    o_busy,
    output logic                    o_timeout_err,
    output logic [SEL_W-1:0]        o_sel_mux_0,
    output logic [SEL_W-1:0]        o_sel_mux_1,
    output logic [PI_W-1:0]         o_pair_idx,
    output logic [NUM_PAIRS-1:0]    o_resp
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        RESET, WAIT, RECEIVE, RO_DECODER, EXECUTE, TRANSMIT, DUMP, ERROR
    } state_t;

    state_t                  r_state, w_next;
    logic [REG_BIT_SIZE-1:0] r_chal;
    logic [SEL_W-1:0]        r_sel0, r_sel1, w_sel0, w_sel1;
    logic [PI_W-1:0]         r_pidx;
    logic [NUM_PAIRS-1:0]    r_resp;
    logic [WD_W-1:0]         r_wdog;
    logic                    r_dbg;
    logic                    w_dbg, w_evt, w_tmo, w_cnt, w_last, w_adv, w_abort, w_degen;

    assign {w_sel1, w_sel0} = r_chal[r_pidx * (2 * SEL_W) +: 2 * SEL_W];
    assign w_degen = w_sel0 == w_sel1;
    assign w_abort = i_abort && r_state != RESET;
    assign w_dbg   = r_dbg | (i_op_mode && (r_state == RO_DECODER || r_state == EXECUTE));
    assign w_cnt   = r_state == RECEIVE || r_state == EXECUTE || r_state == TRANSMIT || r_state == DUMP;
    assign w_evt   = (r_state == RECEIVE) ? (i_rx_valid && i_rx_done) :
                     (r_state == EXECUTE) ? i_exec_done :
                     (r_state == TRANSMIT || r_state == DUMP) ? i_tx_done : 1'b0;
    // the awaited event beats the final watchdog count
    assign w_tmo   = w_cnt && !w_evt && r_wdog == WD_W'(TIMEOUT_CYC - 1);
    assign w_adv   = (r_state == RO_DECODER && w_degen) || (r_state == EXECUTE && i_exec_done);
    assign w_last  = r_pidx == PI_W'(NUM_PAIRS - 1);

    always_comb begin
        w_next = r_state;
        if (w_abort)
            w_next = WAIT;
        else if (w_tmo)
            w_next = ERROR;
        else
            case (r_state)
                RESET:               w_next = WAIT;
                WAIT:                w_next = (i_start && i_rx_ready) ? RECEIVE : WAIT;
                RECEIVE:             w_next = w_evt ? RO_DECODER : RECEIVE;
                RO_DECODER, EXECUTE: w_next = w_adv ? (!w_last ? RO_DECODER : w_dbg ? DUMP : TRANSMIT) :
                                              (r_state == RO_DECODER) ? EXECUTE : EXECUTE;
                TRANSMIT, DUMP:      w_next = w_evt ? WAIT : r_state;
                ERROR:               w_next = i_start ? ERROR : WAIT;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET;
            r_chal  <= '0;
            r_sel0  <= '0;
            r_sel1  <= '0;
            r_pidx  <= '0;
            r_resp  <= '0;
            r_wdog  <= '0;
            r_dbg   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wdog  <= (w_next != r_state || !w_cnt) ? '0 : r_wdog + 1'b1;
            if (w_abort) begin
                r_pidx <= '0;
                r_resp <= '0;
                r_dbg  <= 1'b0;
            end else begin
                if (r_state == RECEIVE && w_evt) begin
                    r_chal <= i_rx_data;
                    r_pidx <= '0;
                    r_resp <= '0;
                    r_dbg  <= 1'b0;
                end else begin
                    r_dbg <= w_dbg;
                end
                if (r_state == RO_DECODER) begin
                    r_sel0 <= w_sel0;
                    r_sel1 <= w_sel1;
                end
                if (r_state == RO_DECODER && w_degen)
                    r_resp[r_pidx] <= 1'b0;
                if (r_state == EXECUTE && i_exec_done)
                    r_resp[r_pidx] <= i_exec_resp;
                if (w_adv && !w_last)
                    r_pidx <= r_pidx + 1'b1;
            end
        end
    end

    assign o_fsm_state   = r_state;
    assign o_dcod_enable = r_state == RO_DECODER;
    assign o_exec_enable = r_state == EXECUTE;
    assign o_tx_enable   = r_state == TRANSMIT;
    assign o_dump_enable = r_state == DUMP;
    assign o_busy        = r_state >= RECEIVE && r_state <= DUMP;
    assign o_timeout_err = r_state == ERROR;
    assign o_sel_mux_0   = r_sel0;
    assign o_sel_mux_1   = r_sel1;
    assign o_pair_idx    = r_pidx;
    assign o_resp        = r_resp;
endmodule

// File: tb/tb_puf_multi_cntrlr.sv
// tb_puf_multi_cntrlr: directed vector table for a normal run plus hand sequences for debug,
// abort, watchdog, degenerate-pair and mid-operation reset behaviour.
module tb_puf_multi_cntrlr;
    localparam logic [8:0] S = 9'h100, RR = 9'h080, RV = 9'h040, RD = 9'h020, ED = 9'h010,
                           ER = 9'h008, TD = 9'h004, OM = 9'h002, AB = 9'h001;
    localparam logic [39:0] D0 = 40'h00_F0E1_D2C3, DG = 40'h00_F077_D2C3;

    typedef struct packed {
        logic [8:0] vi;
        logic [2:0] st;
        logic [3:0] rsp;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [4:0] en;
    } vec_t;

    logic clk = 0, rst_n = 0;
    logic i_start = 0, i_op_mode = 0, i_rx_ready = 0, i_rx_valid = 0, i_rx_done = 0;
    logic i_exec_done = 0, i_exec_resp = 0, i_tx_done = 0, i_abort = 0;
    logic [39:0] i_rx_data = D0;
    logic [2:0] o_fsm_state;
    logic o_dcod_enable, o_exec_enable, o_tx_enable, o_dump_enable, o_busy, o_timeout_err;
    logic [3:0] o_sel_mux_0, o_sel_mux_1;
    logic [1:0] o_pair_idx;
    logic [3:0] o_resp;
    int checks = 0, failures = 0, ex_cnt = 0;
    logic last_ex = 0;
    vec_t tbl[13];

    puf_multi_cntrlr #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op_mode(i_op_mode),
        .i_rx_ready(i_rx_ready), .i_rx_valid(i_rx_valid), .i_rx_done(i_rx_done),
        .i_exec_done(i_exec_done), .i_exec_resp(i_exec_resp), .i_tx_done(i_tx_done),
        .i_abort(i_abort), .i_rx_data(i_rx_data), .o_fsm_state(o_fsm_state),
        .o_dcod_enable(o_dcod_enable), .o_exec_enable(o_exec_enable), .o_tx_enable(o_tx_enable),
        .o_dump_enable(o_dump_enable), .o_busy(o_busy), .o_timeout_err(o_timeout_err),
        .o_sel_mux_0(o_sel_mux_0), .o_sel_mux_1(o_sel_mux_1), .o_pair_idx(o_pair_idx),
        .o_resp(o_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] en_now();
        return {o_busy, o_dcod_enable, o_exec_enable, o_tx_enable, o_dump_enable};
    endfunction

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [8:0] v);
        {i_start, i_rx_ready, i_rx_valid, i_rx_done, i_exec_done, i_exec_resp, i_tx_done,
         i_op_mode, i_abort} = v;
        @(posedge clk);
        #1;
        if (o_exec_enable && !last_ex) ex_cnt++;
        last_ex = o_exec_enable;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_state"}, o_fsm_state, 0);
        chk({nm, "_en"}, {en_now(), o_timeout_err}, 0);
        chk({nm, "_sel"}, {o_sel_mux_0, o_sel_mux_1}, 0);
        chk({nm, "_pidx_resp"}, {o_pair_idx, o_resp}, 0);
    endtask

    initial begin
        tbl[0]  = '{9'h000,  3'd1, 4'h0, 4'h0, 4'h0, 5'b00000};
        tbl[1]  = '{S | RR,  3'd2, 4'h0, 4'h0, 4'h0, 5'b10000};
        tbl[2]  = '{RV | RD, 3'd3, 4'h0, 4'h0, 4'h0, 5'b11000};
        tbl[3]  = '{9'h000,  3'd4, 4'h0, 4'h3, 4'hC, 5'b10100};
        tbl[4]  = '{ED | ER, 3'd3, 4'h1, 4'h3, 4'hC, 5'b11000};
        tbl[5]  = '{9'h000,  3'd4, 4'h1, 4'h2, 4'hD, 5'b10100};
        tbl[6]  = '{ED,      3'd3, 4'h1, 4'h2, 4'hD, 5'b11000};
        tbl[7]  = '{9'h000,  3'd4, 4'h1, 4'h1, 4'hE, 5'b10100};
        tbl[8]  = '{ED | ER, 3'd3, 4'h5, 4'h1, 4'hE, 5'b11000};
        tbl[9]  = '{9'h000,  3'd4, 4'h5, 4'h0, 4'hF, 5'b10100};
        tbl[10] = '{ED | ER, 3'd5, 4'hD, 4'h0, 4'hF, 5'b10010};
        tbl[11] = '{9'h000,  3'd5, 4'hD, 4'h0, 4'hF, 5'b10010};
        tbl[12] = '{TD,      3'd1, 4'hD, 4'h0, 4'hF, 5'b00000};

        #12;
        check_reset_vals("rst");
        rst_n = 1;
        #1;
        chk("rst_release_state", o_fsm_state, 0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].vi);
            chk($sformatf("tbl%0d_state", i), o_fsm_state, tbl[i].st);
            chk($sformatf("tbl%0d_resp", i), o_resp, tbl[i].rsp);
            chk($sformatf("tbl%0d_sel", i), {o_sel_mux_0, o_sel_mux_1}, {tbl[i].s0, tbl[i].s1});
            chk($sformatf("tbl%0d_en", i), en_now(), tbl[i].en);
        end

        // debug: op_mode pulse in pair 1 EXECUTE routes to DUMP
        step(S | RR); step(RV | RD); step(0); step(ED | ER); step(0);
        step(OM);
        chk("dbg_p1_state", o_fsm_state, 4);
        step(ED); step(0); step(ED | ER); step(0); step(ED | ER);
        chk("dbg_dump_state", o_fsm_state, 6);
        chk("dbg_dump_en", en_now(), 5'b10001);
        chk("dbg_resp", o_resp, 4'b1101);
        step(TD);
        chk("dbg_wait", o_fsm_state, 1);

        // abort in pair 2 EXECUTE
        step(S | RR); step(RV | RD); step(0); step(ED | ER); step(0); step(ED); step(0);
        chk("abt_pre", {o_fsm_state, o_pair_idx, o_resp}, {3'd4, 2'd2, 4'b0001});
        step(AB);
        chk("abt_post", {o_fsm_state, o_pair_idx, o_resp}, {3'd1, 2'd0, 4'b0000});

        // exec_done coinciding with the last watchdog count wins
        step(S | RR); step(RV | RD); step(0);
        for (int i = 0; i < 15; i++) step(0);
        chk("coin_pre", o_fsm_state, 4);
        step(ED | ER);
        chk("coin_post", {o_fsm_state, o_resp, o_timeout_err}, {3'd3, 4'b0001, 1'b0});
        step(AB);

        // watchdog expiry after 16 EXECUTE cycles
        step(S | RR); step(RV | RD); step(0);
        for (int i = 0; i < 15; i++) step(0);
        chk("tmo_pre", {o_fsm_state, o_timeout_err}, {3'd4, 1'b0});
        step(0);
        chk("tmo_err", {o_fsm_state, o_timeout_err, o_busy}, {3'd7, 1'b1, 1'b0});
        step(S);
        chk("tmo_hold", {o_fsm_state, o_timeout_err}, {3'd7, 1'b1});
        step(0);
        chk("tmo_clear", {o_fsm_state, o_timeout_err}, {3'd1, 1'b0});

        // degenerate pair 2 (8'h77) skips EXECUTE
        i_rx_data = DG;
        ex_cnt = 0;
        step(S | RR); step(RV | RD); step(0); step(ED | ER); step(0);
        chk("deg_p1_sel", {o_sel_mux_0, o_sel_mux_1}, 8'h2D);
        step(ED); step(0);
        chk("deg_p3_dec", {o_fsm_state, o_pair_idx, o_sel_mux_0, o_sel_mux_1}, {3'd3, 2'd3, 8'h77});
        step(0);
        chk("deg_p3_sel", {o_fsm_state, o_sel_mux_0, o_sel_mux_1}, {3'd4, 8'h0F});
        step(ED | ER);
        chk("deg_tx", {o_fsm_state, o_resp}, {3'd5, 4'b1001});
        chk("deg_exec_windows", ex_cnt, 3);
        step(TD);
        chk("deg_wait_resp_held", {o_fsm_state, o_resp}, {3'd1, 4'b1001});

        // asynchronous reset in RECEIVE
        step(S | RR);
        chk("rst_mid_pre", o_fsm_state, 2);
        #2 rst_n = 0;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1;
        step(0);
        chk("rst_mid_wait", o_fsm_state, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
